// File: rtl/sha_msg_padder.sv
// sha_msg_padder: FIPS 180-4 padder turning a 32-bit word stream into 512-bit SHA-256 blocks.
// Define SHA_PAD_EMPTY_MSG_EN to let in_nbytes_i=0 on a last word mean "no data bytes in this word".
module sha_msg_padder (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_data_i,
  input  logic              in_last_i,
  input  logic [2:0]        in_nbytes_i,
  output logic              blk_valid_o,
  input  logic              blk_ready_i,
  output logic [0:15][31:0] blk_w_o,
  output logic              blk_first_o,
  output logic              blk_last_o
);
  typedef enum logic [2:0] {IDLE, FILL, PAD, EMIT, XTRA} state_t;
  state_t           st_q, st_d;
  logic [0:15][31:0] w_q, w_d;
  logic [3:0]       idx_q, idx_d;
  logic [63:0]      len_q, len_d;
  logic [4:0]       mk_q, mk_d;
  logic [1:0]       mb_q, mb_d;
  logic             first_q, first_d, last_q, last_d, bfirst_q, bfirst_d;
  logic             extra_q, extra_d, spill_q, spill_d;
  logic [2:0]       nb;
  logic [31:0]      keep, marker;
  logic             in_hs;
`ifdef SHA_PAD_EMPTY_MSG_EN
  assign nb = (in_nbytes_i > 3'd4) ? 3'd4 : in_nbytes_i;
`else
  assign nb = (in_nbytes_i == 3'd0 || in_nbytes_i > 3'd4) ? 3'd4 : in_nbytes_i;
`endif
  assign in_ready_o  = st_q == FILL;
  assign blk_valid_o = st_q == EMIT;
  assign blk_w_o     = w_q;
  assign blk_first_o = bfirst_q;
  assign blk_last_o  = last_q;
  assign in_hs       = in_valid_i && in_ready_o;
  // mb_q is the byte slot of the 0x80 marker; bytes below it are cleared of stale input
  assign keep        = (mb_q == 2'd0) ? 32'h0 : ~(32'hffff_ffff >> {mb_q, 3'b000});
  assign marker      = 32'h8000_0000 >> {mb_q, 3'b000};
  always_comb begin
    st_d     = st_q;
    w_d      = w_q;
    idx_d    = idx_q;
    len_d    = len_q;
    mk_d     = mk_q;
    mb_d     = mb_q;
    first_d  = first_q;
    last_d   = last_q;
    bfirst_d = bfirst_q;
    extra_d  = extra_q;
    spill_d  = spill_q;
    case (st_q)
      IDLE: st_d = FILL;
      FILL: if (in_hs) begin
        if (!in_last_i || nb != 3'd0) w_d[idx_q] = in_data_i;
        idx_d = idx_q + 4'd1;
        len_d = len_q + (in_last_i ? {58'd0, nb, 3'd0} : 64'd32);
        if (in_last_i) begin
          st_d = PAD;
          mk_d = {1'b0, idx_q} + {4'd0, nb == 3'd4};
          mb_d = nb[1:0];
        end else if (idx_q == 4'd15) begin
          st_d     = EMIT;
          last_d   = 1'b0;
          bfirst_d = first_q;
        end
      end
      PAD: begin
        for (int i = 0; i < 16; i++)
          w_d[i] = (5'(i) < mk_q) ? w_q[i] : (5'(i) == mk_q) ? ((w_q[i] & keep) | marker) : 32'h0;
        if (mk_q <= 5'd13) begin
          w_d[14] = len_q[63:32];
          w_d[15] = len_q[31:0];
          last_d  = 1'b1;
        end else begin
          last_d  = 1'b0;
          extra_d = 1'b1;
          spill_d = mk_q == 5'd16;
        end
        bfirst_d = first_q;
        st_d     = EMIT;
      end
      EMIT: if (blk_ready_i) begin
        first_d = 1'b0;
        idx_d   = 4'd0;
        st_d    = extra_q ? XTRA : FILL;
        if (!extra_q && last_q) begin
          len_d   = 64'd0;
          first_d = 1'b1;
        end
      end
      XTRA: begin
        w_d      = '0;
        w_d[0]   = spill_q ? 32'h8000_0000 : 32'h0;
        w_d[14]  = len_q[63:32];
        w_d[15]  = len_q[31:0];
        last_d   = 1'b1;
        extra_d  = 1'b0;
        bfirst_d = first_q;
        st_d     = EMIT;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      w_q      <= '0;
      idx_q    <= 4'd0;
      len_q    <= 64'd0;
      mk_q     <= 5'd0;
      mb_q     <= 2'd0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      bfirst_q <= 1'b0;
      extra_q  <= 1'b0;
      spill_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      w_q      <= w_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      mk_q     <= mk_d;
      mb_q     <= mb_d;
      first_q  <= first_d;
      last_q   <= last_d;
      bfirst_q <= bfirst_d;
      extra_q  <= extra_d;
      spill_q  <= spill_d;
    end
  end
endmodule

// File: tb/tb_sha_msg_padder.sv
// tb_sha_msg_padder: directed self-checking bench for sha_msg_padder.
module tb_sha_msg_padder;
  logic              clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
  logic [31:0]       in_data = 32'h0;
  logic [2:0]        in_nbytes = 3'd0;
  logic              in_ready, blk_valid, blk_first, blk_last;
  logic [0:15][31:0] blk_w;
  int                n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  sha_msg_padder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_last_i(in_last), .in_nbytes_i(in_nbytes),
    .blk_valid_o(blk_valid), .blk_ready_i(blk_ready), .blk_w_o(blk_w),
    .blk_first_o(blk_first), .blk_last_o(blk_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL send_wait: in_ready got %b want 1", in_ready); end
    in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_blk();
    int t = 0;
    while (!blk_valid && t < 50) begin tick(); t++; end
    n_cmp++;
    if (blk_valid !== 1'b1) begin n_err++; $display("FAIL blk_wait: blk_valid got %b want 1", blk_valid); end
  endtask

  task automatic accept();
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    n_cmp++;
    if (blk_valid !== 1'b0) begin n_err++; $display("FAIL valid_drop: blk_valid got %b want 0", blk_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({in_ready, blk_valid, blk_first, blk_last} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {in_ready, blk_valid, blk_first, blk_last});
    end
    n_cmp++;
    if (blk_w !== '0) begin n_err++; $display("FAIL reset_w: got %h want 0", blk_w); end
    rst_n = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_release: in_ready got %b want 0", in_ready); end
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_fill: in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_3byte(input string tag);
    logic [0:15][31:0] exp = '0;
    exp[0] = 32'h8702_7980; exp[15] = 32'h0000_0018;
    send(32'h8702_7900, 1'b1, 3'd3);
    n_cmp++;
    if (blk_valid !== 1'b0) begin n_err++; $display("FAIL %s_pad_cycle: blk_valid got %b want 0", tag, blk_valid); end
    tick();
    n_cmp++;
    if (blk_valid !== 1'b1) begin n_err++; $display("FAIL %s_latency: blk_valid got %b want 1", tag, blk_valid); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (blk_w[i] !== exp[i]) begin n_err++; $display("FAIL %s_w%0d: got %h want %h", tag, i, blk_w[i], exp[i]); end
    end
    n_cmp++;
    if ({blk_first, blk_last} !== 2'b11) begin n_err++; $display("FAIL %s_flags: got %b want 11", tag, {blk_first, blk_last}); end
    accept();
  endtask

  task automatic test_partial();
    logic [0:15][31:0] exp = '0;
    exp[0] = 32'h6162_6364; exp[1] = 32'h6580_0000; exp[15] = 32'h0000_0028;
    send(32'h6162_6364, 1'b0, 3'd0);
    send(32'h65FF_FFFF, 1'b1, 3'd1);
    wait_blk();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (blk_w[i] !== exp[i]) begin n_err++; $display("FAIL partial_w%0d: got %h want %h", i, blk_w[i], exp[i]); end
    end
    n_cmp++;
    if ({blk_first, blk_last} !== 2'b11) begin n_err++; $display("FAIL partial_flags: got %b want 11", {blk_first, blk_last}); end
    accept();
  endtask

  task automatic test_56byte();
    logic [0:15][31:0] exp = '0;
    for (int i = 0; i < 14; i++) begin
      exp[i] = 32'(i + 1) * 32'h0101_0101;
      send(exp[i], i == 13, 3'd4);
    end
    exp[14] = 32'h8000_0000;
    wait_blk();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (blk_w[i] !== exp[i]) begin n_err++; $display("FAIL b56a_w%0d: got %h want %h", i, blk_w[i], exp[i]); end
    end
    n_cmp++;
    if ({blk_first, blk_last} !== 2'b10) begin n_err++; $display("FAIL b56a_flags: got %b want 10", {blk_first, blk_last}); end
    accept();
    tick();
    n_cmp++;
    if (blk_valid !== 1'b1) begin n_err++; $display("FAIL b56_extra_latency: blk_valid got %b want 1", blk_valid); end
    exp = '0; exp[15] = 32'h0000_01C0;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (blk_w[i] !== exp[i]) begin n_err++; $display("FAIL b56b_w%0d: got %h want %h", i, blk_w[i], exp[i]); end
    end
    n_cmp++;
    if ({blk_first, blk_last} !== 2'b01) begin n_err++; $display("FAIL b56b_flags: got %b want 01", {blk_first, blk_last}); end
    accept();
  endtask

  task automatic test_64byte();
    logic [0:15][31:0] exp = '0;
    for (int i = 0; i < 16; i++) begin
      exp[i] = 32'hA000_0000 + 32'(i);
      send(exp[i], i == 15, 3'd4);
    end
    wait_blk();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (blk_w[i] !== exp[i]) begin n_err++; $display("FAIL b64a_w%0d: got %h want %h", i, blk_w[i], exp[i]); end
    end
    n_cmp++;
    if ({blk_first, blk_last} !== 2'b10) begin n_err++; $display("FAIL b64a_flags: got %b want 10", {blk_first, blk_last}); end
    accept();
    tick();
    n_cmp++;
    if (blk_valid !== 1'b1) begin n_err++; $display("FAIL b64_extra_latency: blk_valid got %b want 1", blk_valid); end
    exp = '0; exp[0] = 32'h8000_0000; exp[15] = 32'h0000_0200;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (blk_w[i] !== exp[i]) begin n_err++; $display("FAIL b64b_w%0d: got %h want %h", i, blk_w[i], exp[i]); end
    end
    n_cmp++;
    if ({blk_first, blk_last} !== 2'b01) begin n_err++; $display("FAIL b64b_flags: got %b want 01", {blk_first, blk_last}); end
    accept();
  endtask

  task automatic test_backpressure();
    logic [0:15][31:0] hold;
    send(32'h8702_7900, 1'b1, 3'd3);
    wait_blk();
    hold = blk_w;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if ({blk_valid, in_ready} !== 2'b10 || blk_w !== hold) begin
        n_err++; $display("FAIL bp_hold%0d: valid/ready got %b want 10, w0 got %h want %h", c, {blk_valid, in_ready}, blk_w[0], hold[0]);
      end
    end
    accept();
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) send(32'hC0DE_0000 + 32'(i), 1'b0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, blk_valid} !== 2'b00 || blk_w !== '0) begin
      n_err++; $display("FAIL midrst_async: ready/valid got %b want 00, w0 got %h want 0", {in_ready, blk_valid}, blk_w[0]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    test_3byte("replay");
  endtask

  task automatic test_empty();
    logic [0:15][31:0] exp = '0;
`ifdef SHA_PAD_EMPTY_MSG_EN
    exp[0] = 32'h8000_0000;
    send(32'h1234_5678, 1'b1, 3'd0);
`else
    exp[0] = 32'h1234_5678; exp[1] = 32'h8000_0000; exp[15] = 32'h0000_0020;
    send(32'h1234_5678, 1'b1, 3'd0);
`endif
    wait_blk();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (blk_w[i] !== exp[i]) begin n_err++; $display("FAIL nb0_w%0d: got %h want %h", i, blk_w[i], exp[i]); end
    end
    n_cmp++;
    if ({blk_first, blk_last} !== 2'b11) begin n_err++; $display("FAIL nb0_flags: got %b want 11", {blk_first, blk_last}); end
    accept();
  endtask

  initial begin
    test_reset();
    test_3byte("b3");
    test_partial();
    test_56byte();
    test_64byte();
    test_backpressure();
    test_mid_reset();
    test_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
